alu_cmd_sequencer: RTL and testbench

Command front-end for the 8-bit combinational ALU. It buffers {a, b, op} commands in a small FIFO and issues them one at a time to the ALU through registered operand and opcode outputs. It captures result and zero into a registered output with a valid/ready handshake. It also keeps saturating statistics counters. It sits between the test/control logic and the alu instance, and its result port feeds downstream consumers.

---
 rtl/alu_cmd_sequencer_pkg.sv | 27 ++
 rtl/alu_cmd_sequencer_cmd_fifo.sv | 58 +++++
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer_pkg                                  |
// | Description : Shared opcode values and sequencer state encoding.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_cmd_sequencer_pkg;

  localparam int OP_W = 3;

  // ALU opcodes; codes 110 and 111 make the ALU return 0
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer_cmd_fifo                             |
// | Description : Command FIFO with wrap-bit pointers and a              |
// |               combinational head-of-queue read port.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_cmd_sequencer_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  // Same slot with differing wrap bits means every entry is occupied
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  // Full blocks writes even when a read happens in the same cycle
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage is only ever read after being written, so it carries no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointer advance on accepted writes and reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer                                      |
// | Description : Buffers ALU commands, issues them one at a time on     |
// |               registered operands, captures each result behind a     |
// |               valid/ready handshake and keeps saturating counters.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_zero_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  op_count_o,
  output logic [CNT_W-1:0]  zero_count_o
);

  localparam int CMD_W = 2*DATA_W + OP_W;

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              capture;
  logic              res_hs;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_zero_q;
  logic              res_valid_q;
  logic [CNT_W-1:0]  op_count_q, zero_count_q;

  alu_cmd_sequencer_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (cmd_valid_i),
    .wr_data_i ({cmd_a_i, cmd_b_i, cmd_op_i}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: EXEC always lasts one cycle, HOLD waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (res_hs) state_d = fifo_empty ? ST_IDLE : ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM controls: pop a command, capture the ALU, complete a handshake
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    res_hs  = 1'b0;
    case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_EXEC: capture = 1'b1;
      ST_HOLD: begin
        res_hs = res_valid_q && res_ready_i;
        pop    = res_hs && !fifo_empty;
      end
      default: ;
    endcase
  end

  // ALU operand registers keep their last values between commands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else if (pop) begin
      alu_a_q  <= fifo_head[CMD_W-1 -: DATA_W];
      alu_b_q  <= fifo_head[OP_W +: DATA_W];
      alu_op_q <= fifo_head[OP_W-1:0];
    end
  end

  // Result capture after the ALU has settled; valid drops on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (capture) begin
      res_data_q  <= alu_result_i;
      res_zero_q  <= alu_zero_i;
      res_valid_q <= 1'b1;
    end else if (res_hs) begin
      res_valid_q <= 1'b0;
    end
  end

  // Completion counters stick at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q   <= '0;
      zero_count_q <= '0;
    end else if (res_hs) begin
      if (!(&op_count_q))
        op_count_q <= op_count_q + CNT_W'(1);
      if (res_zero_q && !(&zero_count_q))
        zero_count_q <= zero_count_q + CNT_W'(1);
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_zero_o   = res_zero_q;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;
  assign op_count_o   = op_count_q;
  assign zero_count_o = zero_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_cmd_sequencer                                   |
// | Description : Scoreboard bench for alu_cmd_sequencer with a          |
// |               behavioural ALU attached to its operand outputs.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              cmd_valid, cmd_ready;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              res_valid, res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic              busy;
  logic [CNT_W-1:0]  op_count, zero_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ops  = 0;
  int exp_zeros = 0;
  logic [8:0] exp_q [$];
  time        hs_times [$];
  logic       mon_en = 1'b0;
  logic       rec_hs = 1'b0;
  logic       seen_valid;
  logic [8:0] e;

  alu_cmd_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_op_i     (cmd_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_zero_o   (res_zero),
    .busy_o       (busy),
    .op_count_o   (op_count),
    .zero_count_o (zero_count)
  );

  // The combinational ALU the sequencer drives
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = ~alu_a;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {zero, result} computed with integer arithmetic
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      3'd0:    r = (int'(a) + int'(b)) % 256;
      3'd1:    r = (int'(a) - int'(b) + 256) % 256;
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      3'd5:    r = 255 - int'(a);
      default: r = 0;
    endcase
    return {r == 0, 8'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Called at posedge+1; returns at posedge+1 after the command is accepted
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((busy || res_valid || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: counters every cycle, results popped on each handshake
  always @(negedge clk) begin
    if (mon_en) begin
      chk("op_count", 32'(op_count), 32'(exp_ops));
      chk("zero_count", 32'(zero_count), 32'(exp_zeros));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", 32'(res_data), 32'(e[7:0]));
          chk("res_zero", 32'(res_zero), 32'(e[8]));
          if (exp_ops < CNT_MAX) exp_ops++;
          if (e[8] && exp_zeros < CNT_MAX) exp_zeros++;
          if (rec_hs) hs_times.push_back($time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({alu_a, alu_b, alu_op, res_data, res_zero, res_valid}), 32'd0);
    chk("rst_counts", 32'({op_count, zero_count}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Latency of a single ADD into an idle block
    send(3'd0, 8'h05, 8'h03);
    @(negedge clk); chk("lat_e0_valid", 32'(res_valid), 32'd0);
    @(negedge clk); chk("lat_e1_valid", 32'(res_valid), 32'd0);
    @(negedge clk); chk("lat_e2_valid", 32'(res_valid), 32'd1);
    chk("add_data", 32'(res_data), 32'h08);
    @(negedge clk); chk("add_op_count", 32'(op_count), 32'd1);
    @(posedge clk); #1;

    // Two zero results
    send(3'd1, 8'h07, 8'h07);
    send(3'd0, 8'hFF, 8'h01);
    wait_drain();
    chk("zero_count_2", 32'(zero_count), 32'd2);

    // Back-pressure: one in HOLD, four in the FIFO, sixth blocked
    res_ready = 1'b0;
    send(3'd0, 8'h10, 8'h01);
    send(3'd1, 8'h20, 8'h02);
    send(3'd2, 8'h3C, 8'h0F);
    send(3'd3, 8'h40, 8'h04);
    send(3'd4, 8'h55, 8'hFF);
    @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    chk("hold_valid", 32'(res_valid), 32'd1);
    chk("hold_data", 32'(res_data), 32'h11);
    @(posedge clk); #1;
    rec_hs = 1'b1;
    res_ready = 1'b1;
    send(3'd5, 8'h66, 8'h00);
    wait_drain();
    rec_hs = 1'b0;
    chk("burst_results", 32'(hs_times.size()), 32'd6);
    for (int i = 1; i < hs_times.size(); i++)
      chk("burst_gap", 32'(hs_times[i] - hs_times[i-1]), 32'd20);

    // Undefined opcode and NOT
    send(3'd6, 8'hAA, 8'h55);
    send(3'd5, 8'h0F, 8'h00);
    wait_drain();

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 150; i++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      if ($urandom_range(0, 7) == 0) cmd_b = cmd_a;
      @(negedge clk);
      if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_a, cmd_b));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain();
    chk("op_count_saturated", 32'(op_count), 32'(CNT_MAX));

    // Reset while holding a result with three commands queued
    res_ready = 1'b0;
    send(3'd0, 8'h01, 8'h01);
    send(3'd0, 8'h02, 8'h02);
    send(3'd0, 8'h03, 8'h03);
    send(3'd0, 8'h04, 8'h04);
    repeat (2) @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_outputs", 32'({alu_a, alu_b, alu_op, res_data, res_zero, res_valid}), 32'd0);
    chk("mid_rst_counts", 32'({op_count, zero_count}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    exp_ops = 0;
    exp_zeros = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    res_ready = 1'b1;
    mon_en = 1'b1;
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid || busy) seen_valid = 1'b1;
    end
    chk("no_stale_result", 32'(seen_valid), 32'd0);
    @(posedge clk); #1;
    send(3'd3, 8'hA0, 8'h05);
    wait_drain();
    chk("post_rst_op_count", 32'(op_count), 32'd1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
